sp_ram_arb: RTL and testbench

Round-robin arbiter that shares one single-port RAM between `NUM_REQ` requesters, with a bounded burst lock. Each requester issues single-beat read or write commands over a valid/ready handshake. The block sits directly in front of the RAM: it registers the winning command onto the RAM pins and routes the registered read data back to the requester that issued it. One RAM access per cycle; no command is ever dropped once accepted.

---
 rtl/sp_ram_arb.sv | 159 +++++++++++++++
 tb/tb_sp_ram_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arb.sv
// sp_ram_arb
//   Round-robin arbiter sharing one single-port RAM between NUM_REQ requesters,
//   with a bounded burst lock (MAX_BURST consecutive grants while others wait).
//   The winning command is registered onto the RAM pins. Read data returns to the
//   issuing requester two cycles after acceptance.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake (ready is a one-hot grant)
//   req_we            : per-requester write enable (1 = write, 0 = read)
//   req_addr/wdata    : flattened per-requester address / write data
//   rsp_valid         : one-hot read-response strobe
//   rsp_data          : read data (pass-through of ram_dout)
//   grant_id          : index of the current/last owner (registered)
//   ram_wr_en/rd_en   : RAM write / read enables
//   ram_addr/din      : RAM address / write data
//   ram_dout          : RAM registered read data
module sp_ram_arb #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [RAM_WIDTH-1:0]            rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            ram_wr_en,
  output logic                            ram_rd_en,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [RAM_WIDTH-1:0]            ram_din,
  input  logic [RAM_WIDTH-1:0]            ram_dout
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  typedef enum logic {ST_IDLE, ST_OWN} state_e;

  state_e                 state_q, state_d;
  // Current owner while in ST_OWN, last owner while in ST_IDLE.
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [3:0]             burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic                   ram_wr_en_q, ram_wr_en_d;
  logic                   ram_rd_en_q, ram_rd_en_d;
  logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic [RAM_WIDTH-1:0]   ram_din_q, ram_din_d;
  // Response pipeline: stage 1 tracks the command on the RAM pins,
  // stage 2 is the one-hot response strobe itself.
  logic                   s1_rd_q, s1_rd_d;
  logic [ID_W-1:0]        s1_id_q, s1_id_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;

  logic                   win_vld;
  logic [ID_W-1:0]        win_id;
  logic                   accept;

  // Winner selection. Candidates are scanned from owner+1 around to the owner
  // itself, so the owner is the lowest-priority candidate. That single scan
  // covers both the IDLE search from last+1 and the OWN cases "switch to a
  // waiting competitor" and "saturated owner keeps the grant when alone".
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] cand;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    cand    = '0;
    if (state_q == ST_OWN && req_valid[owner_q] && burst_cnt_q < MAX_CNT) begin
      win_vld = 1'b1;
      win_id  = owner_q;
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx  = (32'(owner_q) + k) % NUM_REQ;
        cand = ID_W'(idx);
        if (!win_vld && req_valid[cand]) begin
          win_vld = 1'b1;
          win_id  = cand;
        end
      end
    end
  end

  assign accept    = win_vld & ~rst;
  assign req_ready = accept ? (NUM_REQ'(1) << win_id) : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    grant_id_d  = grant_id_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_wr_en_d = accept & req_we[win_id];
    ram_rd_en_d = accept & ~req_we[win_id];
    s1_rd_d     = accept & ~req_we[win_id];
    s1_id_d     = win_id;
    rsp_valid_d = s1_rd_q ? (NUM_REQ'(1) << s1_id_q) : '0;
    if (accept) begin
      state_d    = ST_OWN;
      owner_d    = win_id;
      grant_id_d = win_id;
      ram_addr_d = req_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
      ram_din_d  = req_wdata[win_id*RAM_WIDTH +: RAM_WIDTH];
      if (state_q == ST_OWN && win_id == owner_q) begin
        burst_cnt_d = (burst_cnt_q < MAX_CNT) ? burst_cnt_q + 4'd1 : MAX_CNT;
      end else begin
        burst_cnt_d = 4'd1;
      end
    end else begin
      state_d     = ST_IDLE;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= ID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      grant_id_q  <= '0;
      ram_wr_en_q <= 1'b0;
      ram_rd_en_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      s1_rd_q     <= 1'b0;
      s1_id_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      grant_id_q  <= grant_id_d;
      ram_wr_en_q <= ram_wr_en_d;
      ram_rd_en_q <= ram_rd_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      s1_rd_q     <= s1_rd_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Responses due in the reset cycle itself belong to discarded reads.
  assign rsp_valid = rst ? '0 : rsp_valid_q;
  assign rsp_data  = ram_dout;
  assign grant_id  = grant_id_q;
  assign ram_wr_en = ram_wr_en_q;
  assign ram_rd_en = ram_rd_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_sp_ram_arb.sv
// tb_sp_ram_arb
//   Self-checking bench for sp_ram_arb with a behavioural RAM, a rule-level
//   arbitration model and a memory model predicting every read response.
module tb_sp_ram_arb;
  localparam int RW = 8;
  localparam int AW = 4;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*RW-1:0] req_wdata;
  logic [RW-1:0]   rsp_data, ram_din, ram_dout;
  logic [IW-1:0]   grant_id;
  logic            ram_wr_en, ram_rd_en;
  logic [AW-1:0]   ram_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sp_ram_arb #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .grant_id(grant_id),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM: writes on negedge, registered read on posedge.
  logic [RW-1:0] ram_mem [2**AW];
  always @(negedge clk) if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
  always @(posedge clk) begin
    if (rst) ram_dout <= '0;
    else if (ram_rd_en) ram_dout <= ram_mem[ram_addr];
  end

  // Reference model state.
  bit            m_idle = 1'b1;
  int            m_owner = N - 1;
  int            m_burst = 0;
  int            m_gid = 0;
  logic [RW-1:0] m_mem [2**AW];
  bit            e_wr = 1'b0, e_rd = 1'b0;
  int            e_addr = 0, e_din = 0;
  bit            s1_rd = 1'b0, s2_rd = 1'b0;
  int            s1_id = 0, s2_id = 0;
  logic [RW-1:0] s1_d = '0, s2_d = '0;

  logic [N*AW-1:0] a_vec;
  logic [N*RW-1:0] d_vec;
  int              last_grant;
  logic [N-1:0]    rsp_seen;
  logic [RW-1:0]   rsp_last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Winner under the arbitration rules, or -1 when nobody is granted.
  function automatic int pred(input logic [N-1:0] v);
    int i;
    if (m_idle) begin
      for (i = 1; i <= N; i++) if (v[(m_owner + i) % N]) return (m_owner + i) % N;
      return -1;
    end
    if (v[m_owner] && m_burst < MB) return m_owner;
    for (i = 1; i < N; i++) if (v[(m_owner + i) % N]) return (m_owner + i) % N;
    if (v[m_owner]) return m_owner;
    return -1;
  endfunction

  // One clock cycle: drive, check at negedge, advance the model.
  task automatic step(input bit r, input logic [N-1:0] v, input logic [N-1:0] we);
    int w;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;
    int addr;
    rst = r; req_valid = v; req_we = we; req_addr = a_vec; req_wdata = d_vec;
    @(negedge clk);
    w = r ? -1 : pred(v);
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    exp_rsp = '0;
    if (!r && s2_rd) exp_rsp[s2_id] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("ready_onehot0", 32'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 32'd1);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (!r && s2_rd) check("rsp_data", 32'(rsp_data), 32'(s2_d));
    check("ram_wr_en", 32'(ram_wr_en), 32'(e_wr));
    check("ram_rd_en", 32'(ram_rd_en), 32'(e_rd));
    if (e_wr || e_rd) check("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_wr) check("ram_din", 32'(ram_din), 32'(e_din));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    rsp_seen |= rsp_valid;
    if (rsp_valid != '0) rsp_last_data = rsp_data;
    last_grant = w;
    s2_rd = s1_rd; s2_id = s1_id; s2_d = s1_d;
    if (w >= 0) begin
      addr   = int'(a_vec[w*AW +: AW]);
      e_wr   = we[w];
      e_rd   = !we[w];
      e_addr = addr;
      e_din  = int'(d_vec[w*RW +: RW]);
      s1_rd  = !we[w];
      s1_id  = w;
      s1_d   = m_mem[addr];
      if (we[w]) m_mem[addr] = d_vec[w*RW +: RW];
      if (!m_idle && w == m_owner) m_burst = (m_burst < MB) ? m_burst + 1 : MB;
      else m_burst = 1;
      m_owner = w;
      m_idle  = 1'b0;
      m_gid   = w;
    end else begin
      e_wr = 1'b0; e_rd = 1'b0; s1_rd = 1'b0;
      m_idle = 1'b1; m_burst = 0;
    end
    if (r) begin
      m_idle = 1'b1; m_owner = N - 1; m_burst = 0; m_gid = 0;
      e_wr = 1'b0; e_rd = 1'b0; s1_rd = 1'b0; s2_rd = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_vec = '0; d_vec = '0;
    rsp_seen = '0; rsp_last_data = '0; last_grant = -1;
    step(1'b1, '0, '0);
    step(1'b1, 4'b1111, '0);
    check("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_din", 32'(ram_din), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);

    // Single write then read of addr 3 by requester 0.
    a_vec = '0; a_vec[0 +: AW] = 4'd3; d_vec = '0; d_vec[0 +: RW] = 8'hA5;
    step(1'b0, 4'b0001, 4'b0001);
    check("first_grant_req0", 32'(last_grant), 32'd0);
    check("wr_pulse", 32'(ram_wr_en), 32'd1);
    step(1'b0, '0, '0);
    check("wr_pulse_end", 32'(ram_wr_en), 32'd0);
    rsp_seen = '0;
    step(1'b0, 4'b0001, 4'b0000);
    step(1'b0, '0, '0);
    check("rd_not_early", 32'(rsp_seen), 32'd0);
    step(1'b0, '0, '0);
    check("rd_rsp_valid", 32'(rsp_seen), 32'b0001);
    check("rd_rsp_data", 32'(rsp_last_data), 32'hA5);

    // Fill every address (lone requester 0 keeps the grant past MAX_BURST).
    for (int i = 0; i < 2**AW; i++) begin
      a_vec = '0; a_vec[0 +: AW] = AW'(i); d_vec = '0; d_vec[0 +: RW] = RW'($urandom);
      step(1'b0, 4'b0001, 4'b0001);
      check("lone_hold", 32'(last_grant), 32'd0);
    end

    // All four requesters valid: groups of MB grants, no bubbles.
    step(1'b1, '0, '0);
    for (int k = 0; k < 4 * N * MB + 2; k++) begin
      a_vec = N*AW'($urandom); d_vec = N*RW'($urandom);
      step(1'b0, 4'b1111, N'($urandom));
      check("rr_sequence", 32'(last_grant), 32'((k / MB) % N));
    end

    // Write by req1 then immediate read by req2 of the same address.
    step(1'b1, '0, '0);
    a_vec = '0; a_vec[1*AW +: AW] = 4'd5; a_vec[2*AW +: AW] = 4'd5;
    d_vec = '0; d_vec[1*RW +: RW] = 8'h3C;
    rsp_seen = '0;
    step(1'b0, 4'b0010, 4'b0010);
    check("mixed_wr_grant", 32'(last_grant), 32'd1);
    step(1'b0, 4'b0100, 4'b0000);
    check("mixed_rd_grant", 32'(last_grant), 32'd2);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    check("raw_rsp_route", 32'(rsp_seen), 32'b0100);
    check("raw_rsp_data", 32'(rsp_last_data), 32'h3C);

    // Owner drops after 2 grants while req3 waits; then lone req3 saturates.
    step(1'b1, '0, '0);
    step(1'b0, 4'b1001, '0);
    check("drop_g1", 32'(last_grant), 32'd0);
    step(1'b0, 4'b1001, '0);
    check("drop_g2", 32'(last_grant), 32'd0);
    step(1'b0, 4'b1000, '0);
    check("drop_switch", 32'(last_grant), 32'd3);
    step(1'b0, 4'b1001, '0);
    check("burst_restart", 32'(last_grant), 32'd3);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'b1000, '0);
      check("sat_hold", 32'(last_grant), 32'd3);
    end
    step(1'b0, 4'b1001, '0);
    check("sat_yield", 32'(last_grant), 32'd0);

    // Reset with two reads in flight.
    step(1'b0, 4'b0001, '0);
    step(1'b0, 4'b0010, '0);
    rsp_seen = '0;
    step(1'b1, 4'b1111, '0);
    step(1'b0, '0, '0);
    check("flush_en_off", 32'({ram_wr_en, ram_rd_en}), 32'd0);
    step(1'b0, '0, '0);
    check("flush_no_rsp", 32'(rsp_seen), 32'd0);
    step(1'b0, 4'b1111, '0);
    check("post_rst_req0", 32'(last_grant), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 10000; k++) begin
      a_vec = N*AW'($urandom); d_vec = N*RW'($urandom);
      step(($urandom_range(0, 999) == 0), N'($urandom), N'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
